// File: rtl/sum_accum_pkg.sv
// Shared types, constants and helpers for the frame-sum accumulator.
package sum_accum_pkg;

   // Frame assembly state: IDLE holds no partial frame, ACCUM holds one.
   typedef enum logic {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

   // Ceiling log2, usable in constant expressions; clog2(1) = 0.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      return r;
   endfunction

   // Default frame length and the sample-counter width it implies.
   localparam int N_SAMP_DEF = 4;
   localparam int CNT_W      = clog2(N_SAMP_DEF);

   // Saturation value of the dropped-frame counter.
   localparam logic [7:0] DROP_MAX = 8'hFF;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with wrap-bit pointers. A push while full is admitted
// only if a pop happens in the same cycle; a pop while empty is ignored.
// Handshake: the caller treats pop as the consumer's ready; a word leaves
// the FIFO on a cycle where !empty && pop, and enters on push && (!full || pop).
module sync_fifo
   import sum_accum_pkg::*;
#(
   parameter  int DW    = 14,
   parameter  int DEPTH = 4,
   localparam int AW    = clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          push,
   input  logic          pop,
   input  logic [DW-1:0] wdata,
   output logic [DW-1:0] rdata,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;
   logic [DW-1:0] mem [DEPTH];
   logic          do_push;
   logic          do_pop;

   // Occupancy flags from the pointer pair; the top bit is the lap (wrap) bit.
   always_comb begin
      full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
      empty   = (wr_ptr == rd_ptr);
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      count   = wr_ptr - rd_ptr;
      rdata   = mem[rd_ptr[AW-1:0]];
   end

   // Pointer and storage update; clear flushes pointers, storage is left alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sum_frame_accum.sv
// Sums every N_SAMP valid input samples into a frame total, queues totals in
// a small FIFO and presents them on a valid/ready port. The input cannot be
// stalled, so totals that arrive while the FIFO is full are dropped and counted.
// Output handshake: a total is transferred on every rising edge where
// out_valid && out_ready; out_data holds steady while out_valid && !out_ready.
module sum_frame_accum
   import sum_accum_pkg::*;
#(
   parameter  int W      = 10,
   parameter  int N_SAMP = 4,
   parameter  int ACC_W  = 14,
   parameter  int DEPTH  = 4,
   localparam int SW     = clog2(N_SAMP),
   localparam int FW     = clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   input  logic [W-1:0]     in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic [FW-1:0]    fifo_count,
   output logic [7:0]       drop_cnt,
   output logic             overflow,
   output state_t           state
);

   state_t           state_n;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_n;
   logic [SW-1:0]    samp_cnt;
   logic [SW-1:0]    samp_cnt_n;
   logic [ACC_W-1:0] sample_ext;
   logic [ACC_W-1:0] total;
   logic             push_req;
   logic             fifo_full;
   logic             fifo_empty;
   logic             drop;

   // Zero-extended sample and the running sum including it.
   always_comb begin
      sample_ext = {{(ACC_W - W){1'b0}}, in_data};
      total      = acc + sample_ext;
   end

   // Frame FSM: next state, accumulator, sample count and push request.
   always_comb begin
      state_n    = state;
      acc_n      = acc;
      samp_cnt_n = samp_cnt;
      push_req   = 1'b0;
      if (clear) begin
         state_n    = IDLE;
         acc_n      = '0;
         samp_cnt_n = '0;
      end else if (in_valid) begin
         unique case (state)
            IDLE: begin
               acc_n      = sample_ext;
               samp_cnt_n = SW'(1);
               state_n    = ACCUM;
            end
            ACCUM: begin
               if (samp_cnt == SW'(N_SAMP - 1)) begin
                  push_req   = 1'b1;
                  acc_n      = '0;
                  samp_cnt_n = '0;
                  state_n    = IDLE;
               end else begin
                  acc_n      = total;
                  samp_cnt_n = samp_cnt + 1'b1;
               end
            end
            default: begin
               state_n    = IDLE;
               acc_n      = '0;
               samp_cnt_n = '0;
            end
         endcase
      end
   end

   // Frame FSM state register with the accumulator and sample count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         acc      <= '0;
         samp_cnt <= '0;
      end else begin
         state    <= state_n;
         acc      <= acc_n;
         samp_cnt <= samp_cnt_n;
      end
   end

   // A completing frame is lost only if the FIFO is full and nothing leaves.
   always_comb begin
      drop = push_req && fifo_full && !(out_valid && out_ready);
   end

   // Dropped-frame statistics: saturating counter and sticky flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt <= '0;
         overflow <= 1'b0;
      end else if (clear) begin
         drop_cnt <= '0;
         overflow <= 1'b0;
      end else if (drop) begin
         overflow <= 1'b1;
         if (drop_cnt != DROP_MAX) begin
            drop_cnt <= drop_cnt + 1'b1;
         end
      end
   end

   sync_fifo #(
      .DW    (ACC_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clear),
      .push  (push_req),
      .pop   (out_ready),
      .wdata (total),
      .rdata (out_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Output is valid whenever the FIFO holds at least one total.
   always_comb begin
      out_valid = !fifo_empty;
   end

endmodule

// File: tb/tb_sum_frame_accum.sv
// Bench for sum_frame_accum: table of frames plus hand-written sequences for
// FIFO-full, simultaneous push/pop, reset/clear mid-frame and drop saturation.
module tb_sum_frame_accum;
   import sum_accum_pkg::*;

   localparam int W      = 10;
   localparam int N_SAMP = 4;
   localparam int ACC_W  = 14;
   localparam int DEPTH  = 4;

   logic             clk;
   logic             rst_n;
   logic             clear;
   logic             in_valid;
   logic [W-1:0]     in_data;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] out_data;
   logic [2:0]       fifo_count;
   logic [7:0]       drop_cnt;
   logic             overflow;
   state_t           state;

   int n_cmp;
   int n_err;

   // Model: expected FIFO contents, partial frame and drop statistics.
   logic [ACC_W-1:0] exp_q[$];
   int               m_acc;
   int               m_cnt;
   int               m_drop;
   int               m_ovf;
   bit               use_tab;
   int               tab_total;

   typedef struct {
      int samp[4];
      int gap;
      int total;
   } frame_vec_t;

   frame_vec_t vecs[6];

   sum_frame_accum #(
      .W      (W),
      .N_SAMP (N_SAMP),
      .ACC_W  (ACC_W),
      .DEPTH  (DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .fifo_count (fifo_count),
      .drop_cnt   (drop_cnt),
      .overflow   (overflow),
      .state      (state)
   );

   // Clock and reset.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard consumer: every transfer must match the oldest expected total.
   always @(negedge clk) begin
      if (rst_n && !clear && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out", 1, 0);
         end else begin
            chk("out_data_pop", int'(out_data), int'(exp_q.pop_front()));
         end
      end
   end

   task automatic model_reset();
      m_acc  = 0;
      m_cnt  = 0;
      m_drop = 0;
      m_ovf  = 0;
      exp_q.delete();
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      clear     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // One cycle: check outputs against the model, drive inputs, update model.
   task automatic cycle(input bit clr, input bit v, input int d, input bit rdy);
      bit pop;
      bit push;
      int tot;
      chk("out_valid", int'(out_valid), (exp_q.size() > 0) ? 1 : 0);
      chk("fifo_count", int'(fifo_count), exp_q.size());
      if (exp_q.size() > 0) chk("out_data_head", int'(out_data), int'(exp_q[0]));
      chk("drop_cnt", int'(drop_cnt), m_drop);
      chk("overflow", int'(overflow), m_ovf);
      chk("state", int'(state), (m_cnt == 0) ? int'(IDLE) : int'(ACCUM));

      clear     = clr;
      in_valid  = v;
      in_data   = d[W-1:0];
      out_ready = rdy;

      if (clr) begin
         model_reset();
      end else begin
         pop  = rdy && (exp_q.size() > 0);
         push = 1'b0;
         tot  = 0;
         if (v) begin
            if (m_cnt == N_SAMP - 1) begin
               push  = 1'b1;
               tot   = m_acc + d;
               m_acc = 0;
               m_cnt = 0;
            end else begin
               m_acc = m_acc + d;
               m_cnt = m_cnt + 1;
            end
         end
         if (push) begin
            if (exp_q.size() == DEPTH && !pop) begin
               m_ovf = 1;
               if (m_drop < 255) m_drop = m_drop + 1;
            end else begin
               exp_q.push_back(use_tab ? ACC_W'(tab_total) : ACC_W'(tot));
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic frame(input int d, input bit rdy);
      for (int i = 0; i < N_SAMP; i++) cycle(1'b0, 1'b1, d, rdy);
   endtask

   task automatic idle(input int n, input bit rdy);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, rdy);
   endtask

   initial begin
      n_cmp   = 0;
      n_err   = 0;
      use_tab = 1'b0;
      tab_total = 0;

      vecs[0] = '{samp: '{1, 2, 3, 4},         gap: 0, total: 10};
      vecs[1] = '{samp: '{1023, 1023, 1023, 1023}, gap: 0, total: 4092};
      vecs[2] = '{samp: '{5, 0, 0, 7},         gap: 3, total: 12};
      vecs[3] = '{samp: '{0, 0, 0, 0},         gap: 0, total: 0};
      vecs[4] = '{samp: '{1000, 1, 2, 3},      gap: 1, total: 1006};
      vecs[5] = '{samp: '{512, 511, 256, 255}, gap: 0, total: 1534};

      do_reset();
      chk("reset_out_data", int'(out_data), 0);
      idle(2, 1'b1);

      // Table of frames with the consumer always ready.
      use_tab = 1'b1;
      foreach (vecs[k]) begin
         tab_total = vecs[k].total;
         for (int i = 0; i < N_SAMP; i++) begin
            cycle(1'b0, 1'b1, vecs[k].samp[i], 1'b1);
            if (i < N_SAMP - 1) idle(vecs[k].gap, 1'b1);
         end
         idle(2, 1'b1);
      end
      use_tab = 1'b0;

      // Five frames into a stalled consumer: one drop, then drain in order.
      for (int f = 0; f < 5; f++) frame(1, 1'b0);
      chk("full_count", int'(fifo_count), 4);
      chk("full_drop", int'(drop_cnt), 1);
      idle(6, 1'b1);

      // Frame completes while full with a pop in the same cycle: no drop.
      for (int f = 0; f < 4; f++) frame(2, 1'b0);
      for (int i = 0; i < N_SAMP - 1; i++) cycle(1'b0, 1'b1, 3, 1'b0);
      cycle(1'b0, 1'b1, 3, 1'b1);
      chk("pushpop_count", int'(fifo_count), 4);
      chk("pushpop_drop", int'(drop_cnt), 1);
      idle(6, 1'b1);

      // Reset in the middle of a frame.
      cycle(1'b0, 1'b1, 9, 1'b1);
      cycle(1'b0, 1'b1, 9, 1'b1);
      do_reset();
      for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b1, i, 1'b1);
      idle(3, 1'b1);

      // Clear in the middle of a frame, with a sample in the clear cycle.
      cycle(1'b0, 1'b1, 9, 1'b1);
      cycle(1'b0, 1'b1, 9, 1'b1);
      cycle(1'b1, 1'b1, 50, 1'b0);
      for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b1, i, 1'b1);
      idle(3, 1'b1);

      // Drop counter saturation, then clear.
      for (int f = 0; f < DEPTH + 260; f++) begin
         for (int i = 0; i < N_SAMP; i++) cycle(1'b0, 1'b1, int'($urandom_range(0, 1023)), 1'b0);
      end
      chk("sat_drop", int'(drop_cnt), 255);
      chk("sat_ovf", int'(overflow), 1);
      cycle(1'b1, 1'b0, 0, 1'b0);
      chk("clr_drop", int'(drop_cnt), 0);
      chk("clr_ovf", int'(overflow), 0);
      chk("clr_count", int'(fifo_count), 0);
      idle(2, 1'b1);

      // Random traffic with random backpressure.
      for (int i = 0; i < 300; i++) begin
         cycle(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 1023)),
               1'($urandom_range(0, 3) != 0));
      end

      // Drain with a bounded budget.
      for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1, 1'b1);
      chk("drain_left", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
